tb_regbus_mem_lat: RTL and testbench
====================================

Name: tb_regbus_mem_lat

Overview:
Parametrised register-bus memory model for system testbenches. It replaces the fixed zero-latency regbus memory: data width, depth, base address and response latency are configurable, and out-of-range accesses can raise an error. One instance sits behind each regbus port of the top level, for example bootrom and clock-manager windows. Synthesizable subset only, so emulation builds can reuse it.

Parameters:
AddrWidth, 48, request address width in bits
DataWidth, 32, data width in bits; must be 32 or 64
NumWords, 1024, memory depth in DataWidth-sized words; must be at least 1
BaseAddr, 0, byte address mapped to word 0
Latency, 0, response latency in cycles; 0 to 15
ErrOnOob, 1, 1 means an out-of-bounds access returns error_o=1

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
valid_i  in  1  request valid
write_i  in  1  1 = write, 0 = read
addr_i  in  AddrWidth  byte address
wdata_i  in  DataWidth  write data
wstrb_i  in  DataWidth/8  byte strobes
ready_o  out  1  request accepted and response valid this cycle
rdata_o  out  DataWidth  read data, valid when ready_o=1
error_o  out  1  error response, valid when ready_o=1
rd_cnt_o  out  32  completed reads (optional feature)
wr_cnt_o  out  32  completed writes (optional feature)

Behaviour:
- Clocking/reset: one clock, clk_i. rst_ni is synchronous and active-low.
- Address decode:
  - idx = (addr_i - BaseAddr) >> log2(DataWidth/8); low address bits are ignored.
  - An access is out-of-bounds (oob) if addr_i < BaseAddr or idx >= NumWords.
- Handshake:
  - A transaction completes in the cycle where valid_i=1 and ready_o=1.
  - The requester holds addr_i, write_i, wdata_i and wstrb_i stable while valid_i=1 until completion.
- Latency=0: no FSM.
  - ready_o = valid_i & rst_ni.
  - rdata_o and error_o are combinational from the current request.
  - A write is committed at the clock edge of the completing cycle.
- Latency>0: FSM with states IDLE and WAIT, plus a 4-bit counter cnt.
  - IDLE with valid_i=1: go to WAIT, cnt=1, ready_o=0.
  - WAIT with cnt<Latency: cnt+1.
  - WAIT with cnt==Latency: ready_o=1 and response driven this cycle; next state IDLE.
  - Result: the first valid cycle is t0 and ready_o rises at t0+Latency. Back-to-back requests each pay the full latency, with one IDLE cycle between them.
  - valid_i dropping in WAIT (protocol violation): return to IDLE, no write, and a simulation-only assertion fires.
- Read data:
  - Memory word at idx when write_i=0.
  - 0 for writes and for oob accesses.
- Writes: only bytes with wstrb_i[b]=1 are updated. wstrb_i=0 completes normally with no change.
- Out-of-bounds: never written. error_o=ErrOnOob and rdata_o=0.
- Reset values: ready_o=0, rdata_o=0, error_o=0, FSM=IDLE, cnt=0, counters=0.
  - Memory contents are not reset; contents are undefined until written.
- Reset during WAIT: FSM returns to IDLE on that edge, no write is committed, and no response is produced.

Optional Feature:
TB_REGBUS_MEM_STATS_EN
- Defined:
  - rd_cnt_o and wr_cnt_o increment by 1 on each completed read or write, including oob and error responses.
  - Both wrap modulo 2^32.
  - Both are cleared by reset.
- Undefined: rd_cnt_o and wr_cnt_o are tied to 0 and no counter flops exist.

Test Plan:
- Latency=0, DataWidth=32: write 0xDEADBEEF to 0x10 with wstrb 0xF, then read 0x10 -> ready_o is in the same cycle as valid_i; rdata_o=0xDEADBEEF; error_o=0.
- Byte strobes: write 0xAABBCCDD to 0x20 with wstrb 0xF, then write 0x11223344 with wstrb 0x5, then read 0x20 -> rdata_o=0xAA22CC44.
- Latency=3: read with valid_i rising at t0 -> ready_o=0 at t0 to t0+2 and ready_o=1 at t0+3. A back-to-back second read -> its ready_o at t0+7.
- NumWords=16, BaseAddr=0x1000, ErrOnOob=1:
  - Write to 0x1040 -> error_o=1.
  - Read 0x0FFC -> error_o=1 and rdata_o=0.
  - Read 0x103C -> error_o=0.
  - With ErrOnOob=0, the same oob accesses -> error_o=0 and rdata_o=0.
- Latency=4: assert rst_ni=0 at t0+2 of a pending write to 0x0 -> no ready_o; a later read of 0x0 returns the prior content.
- With TB_REGBUS_MEM_STATS_EN: 5 reads, 3 writes and 1 oob read -> rd_cnt_o=6, wr_cnt_o=3. After reset -> both 0.

Source files
------------

// File: rtl/tb_regbus_mem_lat.sv
// Register-bus memory model with configurable width, depth, base address
// and response latency. Out-of-range accesses are never written and may
// answer with an error.
// Optional feature macro: TB_REGBUS_MEM_STATS_EN adds completed read/write
// counters on rd_cnt_o / wr_cnt_o. Without it both outputs are tied to 0.
module tb_regbus_mem_lat #(
    parameter int unsigned     AddrWidth = 48,
    parameter int unsigned     DataWidth = 32,
    parameter int unsigned     NumWords  = 1024,
    parameter longint unsigned BaseAddr  = 0,
    parameter int unsigned     Latency   = 0,
    parameter bit              ErrOnOob  = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic                   write_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    output logic                   ready_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   error_o,
    output logic [31:0]            rd_cnt_o,
    output logic [31:0]            wr_cnt_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [AddrWidth-1:0] BASE_A  = AddrWidth'(BaseAddr);
    localparam logic [AddrWidth-1:0] WORDS_A = AddrWidth'(NumWords);

    if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_dw
        $error("tb_regbus_mem_lat: DataWidth must be 32 or 64");
    end
    if (NumWords < 1) begin : g_bad_nw
        $error("tb_regbus_mem_lat: NumWords must be at least 1");
    end
    if (Latency > 15) begin : g_bad_lat
        $error("tb_regbus_mem_lat: Latency must be 0 to 15");
    end

    logic [DataWidth-1:0] r_mem [NumWords];

    logic [AddrWidth-1:0] w_off;
    logic [AddrWidth-1:0] w_word;
    logic [IdxW-1:0]      w_idx;
    logic                 w_below;
    logic                 w_oob;
    logic                 w_err;
    logic [DataWidth-1:0] w_rd_data;
    logic                 w_commit;
    logic                 w_done;

    // Address decode: word index relative to the base, low byte bits dropped.
    // The subtraction wraps for addresses below the base, which is why the
    // below-base test is kept separately.
    always_comb begin
        w_off     = addr_i - BASE_A;
        w_word    = w_off >> OffW;
        w_below   = (addr_i < BASE_A);
        w_oob     = w_below | (w_word >= WORDS_A);
        w_idx     = w_word[IdxW-1:0];
        w_err     = w_oob & ErrOnOob;
        w_rd_data = (!write_i && !w_oob) ? r_mem[w_idx] : '0;
    end

    // Byte-strobed memory write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            for (int b = 0; b < StrbW; b++) begin
                if (wstrb_i[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    if (Latency == 0) begin : g_comb
        // Zero-latency path: answer in the same cycle as the request.
        always_comb begin
            ready_o  = valid_i & rst_ni;
            rdata_o  = ready_o ? w_rd_data : '0;
            error_o  = ready_o & w_err;
            w_commit = ready_o & write_i & ~w_oob;
        end
    end else begin : g_fsm
        // state | meaning
        // IDLE  | no request in flight; a valid request starts the count
        // WAIT  | counting cycles; response is presented when cnt == Latency
        typedef enum logic {
            ST_IDLE = 1'b0,
            ST_WAIT = 1'b1
        } state_t;

        localparam logic [3:0] LAT = 4'(Latency);

        state_t               r_state;
        logic [3:0]           r_cnt;
        logic                 r_ready;
        logic [DataWidth-1:0] r_rdata;
        logic                 r_err;

        // Request sequencer. The response registers are loaded on the edge
        // before cnt reaches Latency so ready_o is high exactly in that cycle.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_ready <= 1'b0;
                r_rdata <= '0;
                r_err   <= 1'b0;
            end else begin
                r_ready <= 1'b0;
                r_rdata <= '0;
                r_err   <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (valid_i) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'd1;
                            if (LAT == 4'd1) begin
                                r_ready <= 1'b1;
                                r_rdata <= w_rd_data;
                                r_err   <= w_err;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (!valid_i || (r_cnt == LAT)) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                            if ((r_cnt + 4'd1) == LAT) begin
                                r_ready <= 1'b1;
                                r_rdata <= w_rd_data;
                                r_err   <= w_err;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        // Registered response; a write lands only if the request is still
        // held valid in the response cycle and reset is not asserted.
        always_comb begin
            ready_o  = r_ready;
            rdata_o  = r_rdata;
            error_o  = r_err;
            w_commit = r_ready & valid_i & rst_ni & write_i & ~w_oob;
        end

`ifndef SYNTHESIS
        a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (r_state == ST_WAIT) |-> valid_i);
`endif
    end

    // A transaction completes when ready and valid meet outside reset.
    always_comb begin
        w_done = ready_o & valid_i & rst_ni;
    end

`ifdef TB_REGBUS_MEM_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    // Completed-transaction counters, including error responses; wrap freely.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_done) begin
            if (write_i) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end else begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
        end
    end

    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
`else
    logic w_done_unused;

    // Counters compiled out; completion is only observed by the bus.
    always_comb begin
        w_done_unused = w_done;
    end

    assign rd_cnt_o = '0;
    assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tb_regbus_mem_lat.sv
// Directed bench for tb_regbus_mem_lat: several instances cover zero
// latency, out-of-bounds handling with and without error, latency 3
// back-to-back timing and reset during a pending latency-4 write.
module tb_tb_regbus_mem_lat;

    logic        clk;
    logic        rst_n;
    logic        rst_l4;
    logic        wr;
    logic [47:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        vld [5];
    logic        rdy [5];
    logic [31:0] rdt [5];
    logic        err [5];
    logic [31:0] rdc [5];
    logic [31:0] wrc [5];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          dut;
        logic        wr;
        logic [47:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to measure response latency.
    always @(posedge clk) cyc <= cyc + 1;

    tb_regbus_mem_lat #(.Latency(0), .NumWords(1024), .BaseAddr(0)) u_l0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vld[0]), .write_i(wr),
        .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb), .ready_o(rdy[0]),
        .rdata_o(rdt[0]), .error_o(err[0]), .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0]));

    tb_regbus_mem_lat #(.Latency(0), .NumWords(16), .BaseAddr('h1000), .ErrOnOob(1'b1)) u_oob1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vld[1]), .write_i(wr),
        .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb), .ready_o(rdy[1]),
        .rdata_o(rdt[1]), .error_o(err[1]), .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1]));

    tb_regbus_mem_lat #(.Latency(0), .NumWords(16), .BaseAddr('h1000), .ErrOnOob(1'b0)) u_oob0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vld[2]), .write_i(wr),
        .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb), .ready_o(rdy[2]),
        .rdata_o(rdt[2]), .error_o(err[2]), .rd_cnt_o(rdc[2]), .wr_cnt_o(wrc[2]));

    tb_regbus_mem_lat #(.Latency(3), .NumWords(64)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vld[3]), .write_i(wr),
        .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb), .ready_o(rdy[3]),
        .rdata_o(rdt[3]), .error_o(err[3]), .rd_cnt_o(rdc[3]), .wr_cnt_o(wrc[3]));

    tb_regbus_mem_lat #(.Latency(4), .NumWords(64)) u_l4 (
        .clk_i(clk), .rst_ni(rst_l4), .valid_i(vld[4]), .write_i(wr),
        .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb), .ready_o(rdy[4]),
        .rdata_o(rdt[4]), .error_o(err[4]), .rd_cnt_o(rdc[4]), .wr_cnt_o(wrc[4]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge and hold it until ready (bounded).
    // Returns the cycle index of the ready cycle, or -1 on timeout.
    task automatic run_lat(input int d, input logic w, input logic [47:0] a,
                           input logic [31:0] wd, input logic [3:0] ws,
                           output int rc, output logic [31:0] rd, output logic er);
        rc = -1;
        rd = '0;
        er = 1'b0;
        wr = w; addr = a; wdata = wd; wstrb = ws;
        vld[d] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (rdy[d]) begin
                rc = cyc;
                rd = rdt[d];
                er = err[d];
                break;
            end
            @(negedge clk);
        end
        if (rc < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: no ready within 20 cycles", d);
            vld[d] = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            #1;
            vld[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int          t0;
        int          rc;
        int          rc2;
        logic [31:0] rd;
        logic        er;
        logic        seen;
        int          exp_rd_cnt;
        int          exp_wr_cnt;

        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        rst_n  = 1'b0;
        rst_l4 = 1'b0;
        wr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        for (int i = 0; i < 5; i++) vld[i] = 1'b0;
        repeat (3) @(negedge clk);

        vld[0] = 1'b1;
        #1;
        chk("rst_l0_ready", 64'(rdy[0]), 64'd0);
        vld[0] = 1'b0;
        chk("rst_l3_ready", 64'(rdy[3]), 64'd0);
        chk("rst_l3_rdata", 64'(rdt[3]), 64'd0);
        chk("rst_l4_error", 64'(err[4]), 64'd0);
        chk("rst_rd_cnt",   64'(rdc[0]), 64'd0);
        chk("rst_wr_cnt",   64'(wrc[0]), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst_l4 = 1'b1;
        @(negedge clk);

        // dut, wr, addr, wdata, wstrb, exp_rdata, exp_error
        vecs.push_back('{0, 1'b1, 48'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 48'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 48'h20,   32'hAABBCCDD, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 48'h20,   32'h11223344, 4'h5, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 48'h20,   32'h0,        4'h0, 32'hAA22CC44, 1'b0});
        vecs.push_back('{0, 1'b0, 48'h13,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 48'h10,   32'h0,        4'h0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 48'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 48'hFFC,  32'h0BADF00D, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 48'hFFC,  32'h0,        4'h0, 32'h0BADF00D, 1'b0});
        vecs.push_back('{0, 1'b0, 48'h1000, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1, 1'b1, 48'h103C, 32'h12345678, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 48'h103C, 32'h0,        4'h0, 32'h12345678, 1'b0});
        vecs.push_back('{1, 1'b1, 48'h1000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b1, 48'h1040, 32'h55555555, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1, 1'b0, 48'h1000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1, 1'b0, 48'h0FFC, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1, 1'b0, 48'h1040, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{2, 1'b1, 48'h103C, 32'h87654321, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b1, 48'h1040, 32'h55555555, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b0, 48'h0FFC, 32'h0,        4'h0, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b0, 48'h1040, 32'h0,        4'h0, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b0, 48'h103C, 32'h0,        4'h0, 32'h87654321, 1'b0});

        foreach (vecs[i]) begin
            wr = vecs[i].wr; addr = vecs[i].addr;
            wdata = vecs[i].wdata; wstrb = vecs[i].wstrb;
            vld[vecs[i].dut] = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(rdy[vecs[i].dut]), 64'd1);
            chk($sformatf("v%0d_rdata", i), 64'(rdt[vecs[i].dut]), 64'(vecs[i].exp_rd));
            chk($sformatf("v%0d_error", i), 64'(err[vecs[i].dut]), 64'(vecs[i].exp_err));
            @(posedge clk);
            #1;
            vld[vecs[i].dut] = 1'b0;
            @(negedge clk);
            if (vecs[i].dut == 0) begin
                if (vecs[i].wr) exp_wr_cnt++;
                else            exp_rd_cnt++;
            end
        end

`ifdef TB_REGBUS_MEM_STATS_EN
        chk("stats_rd_cnt", 64'(rdc[0]), 64'(exp_rd_cnt));
        chk("stats_wr_cnt", 64'(wrc[0]), 64'(exp_wr_cnt));
`else
        chk("stats_rd_tied", 64'(rdc[0]), 64'd0);
        chk("stats_wr_tied", 64'(wrc[0]), 64'd0);
`endif

        // Latency 3: single write, then two back-to-back reads.
        t0 = cyc;
        run_lat(3, 1'b1, 48'h8, 32'h5A5A5A5A, 4'hF, rc, rd, er);
        chk("l3_wr_lat", 64'(rc - t0), 64'd3);
        t0 = cyc;
        run_lat(3, 1'b0, 48'h8, 32'h0, 4'h0, rc, rd, er);
        chk("l3_rd1_lat", 64'(rc - t0), 64'd3);
        chk("l3_rd1_data", 64'(rd), 64'h5A5A5A5A);
        chk("l3_rd1_err", 64'(er), 64'd0);
        run_lat(3, 1'b0, 48'h8, 32'h0, 4'h0, rc2, rd, er);
        chk("l3_rd2_lat", 64'(rc2 - t0), 64'd7);
        chk("l3_rd2_data", 64'(rd), 64'h5A5A5A5A);
        #1;
        chk("l3_ready_drop", 64'(rdy[3]), 64'd0);

        // Latency 4: prior content, then reset in the middle of a write.
        t0 = cyc;
        run_lat(4, 1'b1, 48'h0, 32'h01020304, 4'hF, rc, rd, er);
        chk("l4_wr_lat", 64'(rc - t0), 64'd4);
        wr = 1'b1; addr = 48'h0; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        vld[4] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (rdy[4]) seen = 1'b1;
            @(negedge clk);
        end
        rst_l4 = 1'b0;
        vld[4] = 1'b0;
        @(negedge clk);
        rst_l4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rdy[4]) seen = 1'b1;
            @(negedge clk);
        end
        chk("l4_rst_no_ready", 64'(seen), 64'd0);
        t0 = cyc;
        run_lat(4, 1'b0, 48'h0, 32'h0, 4'h0, rc, rd, er);
        chk("l4_rd_lat", 64'(rc - t0), 64'd4);
        chk("l4_rd_prior", 64'(rd), 64'h01020304);

        // Reset clears the statistics counters.
        rst_n = 1'b0;
        @(negedge clk);
        chk("final_rst_rd_cnt", 64'(rdc[0]), 64'd0);
        chk("final_rst_wr_cnt", 64'(wrc[0]), 64'd0);
        chk("final_rst_l3_ready", 64'(rdy[3]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
